// File: rtl/redirect_flush_seq.sv
// rtl/redirect_flush_seq.sv - PC owner and redirect/flush sequencer for the 5-stage MIPS core
//
// Purpose:
//   Holds the program counter and converts ID-stage control-transfer decisions
//   (jr, taken bne, jump) and load-use stall requests into registered PC
//   updates, IF/ID and ID/EX flush strobes, and pipeline write enables.
//   Redirects that arrive while instruction memory is not ready are held
//   pending until the fetch can be accepted.
//
// Ports:
//   clk, reset_n                 core clock, asynchronous active-low reset
//   jump, bne, jr                ID-stage control-transfer decisions
//   jump_addr, bne_addr, jr_addr targets for the above
//   load_use                     ID-stage load-use hazard
//   imem_ready                   instruction memory accepts a fetch at pc
//   pc                           current fetch address (registered)
//   pc_write, ifid_write         combinational advance / IF/ID load enables
//   IF_flush, ID_flush           registered flush strobes
//   redirect_cnt, stall_cnt      saturating event counters

module redirect_flush_seq #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
   parameter int unsigned       CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              jump,
   input  logic              bne,
   input  logic              jr,
   input  logic [ADDR_W-1:0] jump_addr,
   input  logic [ADDR_W-1:0] bne_addr,
   input  logic [ADDR_W-1:0] jr_addr,
   input  logic              load_use,
   input  logic              imem_ready,
   output logic [ADDR_W-1:0] pc,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              IF_flush,
   output logic              ID_flush,
   output logic [CNT_W-1:0]  redirect_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [1:0] ST_RUN   = 2'd0;
   localparam logic [1:0] ST_REDIR = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};
   localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              if_flush_q, if_flush_d;
   logic              id_flush_q, id_flush_d;
   logic [ADDR_W-1:0] tgt_q, tgt_d;
   // Whether the pending redirect also kills the ID/EX slot (jr/bne do, jump does not).
   logic              tgt_idf_q, tgt_idf_d;
   logic [CNT_W-1:0]  redirect_cnt_q, redirect_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic              req_any;
   logic [ADDR_W-1:0] sel_tgt;
   logic              sel_idf;
   logic [ADDR_W-1:0] pc_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : (v + CNT_ONE);
   endfunction

   // Redirect source selection: jr > bne > jump.
   always_comb begin
      req_any = jr | bne | jump;
      sel_tgt = jump_addr;
      sel_idf = 1'b0;
      if (jr) begin
         sel_tgt = jr_addr;
         sel_idf = 1'b1;
      end else if (bne) begin
         sel_tgt = bne_addr;
         sel_idf = 1'b1;
      end
   end

   // Sequential fetch address; wraps naturally modulo 2^ADDR_W.
   assign pc_inc = pc_q + PC_STEP;

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      if_flush_d     = 1'b0;
      id_flush_d     = 1'b0;
      tgt_d          = tgt_q;
      tgt_idf_d      = tgt_idf_q;
      redirect_cnt_d = redirect_cnt_q;
      stall_cnt_d    = stall_cnt_q;
      pc_write       = 1'b0;
      ifid_write     = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (load_use) begin
               // Stall outranks redirects: the instruction in ID is
               // re-presented next cycle and re-decides.
               id_flush_d  = 1'b1;
               stall_cnt_d = sat_inc(stall_cnt_q);
            end else if (req_any) begin
               tgt_d      = sel_tgt;
               tgt_idf_d  = sel_idf;
               if_flush_d = 1'b1;
               if (imem_ready) begin
                  pc_d           = sel_tgt;
                  pc_write       = 1'b1;
                  ifid_write     = 1'b1;
                  id_flush_d     = sel_idf;
                  redirect_cnt_d = sat_inc(redirect_cnt_q);
                  state_d        = ST_REDIR;
               end else begin
                  state_d = ST_WAIT;
               end
            end else if (imem_ready) begin
               pc_d       = pc_inc;
               pc_write   = 1'b1;
               ifid_write = 1'b1;
            end
         end

         ST_REDIR: begin
            // ID holds a flushed slot, so requests this cycle are ignored.
            state_d = ST_RUN;
            if (imem_ready) begin
               pc_d       = pc_inc;
               pc_write   = 1'b1;
               ifid_write = 1'b1;
            end
         end

         ST_WAIT: begin
            // Keep IF/ID flushed so stale contents never issue while waiting.
            if_flush_d = 1'b1;
            if (imem_ready) begin
               pc_d           = tgt_q;
               pc_write       = 1'b1;
               id_flush_d     = tgt_idf_q;
               redirect_cnt_d = sat_inc(redirect_cnt_q);
               state_d        = ST_REDIR;
            end
         end

         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_RUN;
         pc_q           <= RESET_PC;
         if_flush_q     <= 1'b0;
         id_flush_q     <= 1'b0;
         tgt_q          <= {ADDR_W{1'b0}};
         tgt_idf_q      <= 1'b0;
         redirect_cnt_q <= {CNT_W{1'b0}};
         stall_cnt_q    <= {CNT_W{1'b0}};
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         if_flush_q     <= if_flush_d;
         id_flush_q     <= id_flush_d;
         tgt_q          <= tgt_d;
         tgt_idf_q      <= tgt_idf_d;
         redirect_cnt_q <= redirect_cnt_d;
         stall_cnt_q    <= stall_cnt_d;
      end
   end

   assign pc           = pc_q;
   assign IF_flush     = if_flush_q;
   assign ID_flush     = id_flush_q;
   assign redirect_cnt = redirect_cnt_q;
   assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_redirect_flush_seq.sv
// tb/tb_redirect_flush_seq.sv - self-checking bench for redirect_flush_seq

module tb_redirect_flush_seq;

   localparam int AW   = 32;
   localparam int CW   = 10;
   localparam int CMAX = (1 << CW) - 1;
   localparam logic [AW-1:0] RPC = 32'h0000_0000;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          jump, bne, jr, load_use, imem_ready;
   logic [AW-1:0] jump_addr, bne_addr, jr_addr;
   logic [AW-1:0] pc;
   logic          pc_write, ifid_write, IF_flush, ID_flush;
   logic [CW-1:0] redirect_cnt, stall_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: pipeline view of the sequencer.
   logic [AW-1:0] m_pc, m_tgt;
   bit            m_pend, m_redir, m_if, m_id, m_tidf;
   int            m_rc, m_sc;

   redirect_flush_seq #(.ADDR_W(AW), .RESET_PC(RPC), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n),
      .jump(jump), .bne(bne), .jr(jr),
      .jump_addr(jump_addr), .bne_addr(bne_addr), .jr_addr(jr_addr),
      .load_use(load_use), .imem_ready(imem_ready),
      .pc(pc), .pc_write(pc_write), .ifid_write(ifid_write),
      .IF_flush(IF_flush), .ID_flush(ID_flush),
      .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      jump = 0; bne = 0; jr = 0; load_use = 0;
   endtask

   task automatic model_reset();
      m_pc = RPC; m_tgt = '0; m_pend = 0; m_redir = 0;
      m_if = 0; m_id = 0; m_tidf = 0; m_rc = 0; m_sc = 0;
   endtask

   // One clock: check outputs at negedge against the model, then advance the model.
   task automatic step();
      bit e_pcw, e_ifw, n_if, n_id;
      @(negedge clk);
      if (m_redir) begin
         e_pcw = imem_ready; e_ifw = imem_ready;
      end else if (m_pend) begin
         e_pcw = imem_ready; e_ifw = 0;
      end else begin
         e_pcw = imem_ready && !load_use; e_ifw = e_pcw;
      end
      chk("pc", 64'(pc), 64'(m_pc));
      chk("IF_flush", 64'(IF_flush), 64'(m_if));
      chk("ID_flush", 64'(ID_flush), 64'(m_id));
      chk("redirect_cnt", 64'(redirect_cnt), 64'(m_rc));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_sc));
      chk("pc_write", 64'(pc_write), 64'(e_pcw));
      chk("ifid_write", 64'(ifid_write), 64'(e_ifw));

      n_if = 0; n_id = 0;
      if (m_redir) begin
         m_redir = 0;
         if (imem_ready) m_pc = m_pc + 4;
      end else if (m_pend) begin
         n_if = 1;
         if (imem_ready) begin
            m_pc = m_tgt; m_pend = 0; m_redir = 1; n_id = m_tidf;
            if (m_rc < CMAX) m_rc++;
         end
      end else if (load_use) begin
         n_id = 1;
         if (m_sc < CMAX) m_sc++;
      end else if (jr || bne || jump) begin
         m_tgt  = jr ? jr_addr : (bne ? bne_addr : jump_addr);
         m_tidf = jr || bne;
         n_if   = 1;
         if (imem_ready) begin
            m_pc = m_tgt; m_redir = 1; n_id = m_tidf;
            if (m_rc < CMAX) m_rc++;
         end else begin
            m_pend = 1;
         end
      end else if (imem_ready) begin
         m_pc = m_pc + 4;
      end
      m_if = n_if; m_id = n_id;
      @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; checks the asynchronous clear mid-cycle.
   task automatic do_reset();
      reset_n = 0;
      #2;
      chk("rst_pc", 64'(pc), 64'(RPC));
      chk("rst_IF_flush", 64'(IF_flush), 64'd0);
      chk("rst_ID_flush", 64'(ID_flush), 64'd0);
      chk("rst_redirect_cnt", 64'(redirect_cnt), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1;
      model_reset();
   endtask

   initial begin
      reset_n = 1; imem_ready = 1; idle();
      jump_addr = '0; bne_addr = '0; jr_addr = '0;
      @(posedge clk); #1;
      do_reset();

      // Reset while in the redirect flush cycle.
      jump = 1; jump_addr = 32'h500; step(); idle();
      chk("redir_before_rst", 64'(IF_flush), 64'd1);
      do_reset();
      chk("post_rst_pc0", 64'(pc), 64'h0); step();
      chk("post_rst_pc4", 64'(pc), 64'h4); step();
      chk("post_rst_pc8", 64'(pc), 64'h8);
      step(); step();
      chk("pc_10", 64'(pc), 64'h10);

      // Taken bne.
      bne = 1; bne_addr = 32'h40; step(); idle();
      chk("bne_pc", 64'(pc), 64'h40);
      chk("bne_IF_flush", 64'(IF_flush), 64'd1);
      chk("bne_ID_flush", 64'(ID_flush), 64'd1);
      step();
      chk("bne_pc44", 64'(pc), 64'h44);
      chk("bne_IF_flush_off", 64'(IF_flush), 64'd0);
      chk("bne_redirect_cnt", 64'(redirect_cnt), 64'd1);

      // jr outranks jump; jump alone does not flush ID/EX.
      jump = 1; jump_addr = 32'h80; jr = 1; jr_addr = 32'h200; step(); idle();
      chk("jr_pc", 64'(pc), 64'h200);
      chk("jr_ID_flush", 64'(ID_flush), 64'd1);
      step();
      jump = 1; jump_addr = 32'h80; step(); idle();
      chk("jump_pc", 64'(pc), 64'h80);
      chk("jump_ID_flush", 64'(ID_flush), 64'd0);
      chk("jump_IF_flush", 64'(IF_flush), 64'd1);
      step();

      // load_use beats jr at pc=0x20.
      do_reset();
      repeat (8) step();
      chk("lu_pc_pre", 64'(pc), 64'h20);
      load_use = 1; jr = 1; jr_addr = 32'h300;
      #1;
      chk("lu_ifid_write", 64'(ifid_write), 64'd0);
      chk("lu_pc_write", 64'(pc_write), 64'd0);
      step(); idle();
      chk("lu_pc_hold", 64'(pc), 64'h20);
      chk("lu_ID_flush", 64'(ID_flush), 64'd1);
      chk("lu_stall_cnt", 64'(stall_cnt), 64'd1);
      chk("lu_redirect_cnt", 64'(redirect_cnt), 64'd0);
      step();

      // Back-to-back stalls.
      load_use = 1; repeat (4) step(); idle();
      chk("lu_b2b_stall_cnt", 64'(stall_cnt), 64'd5);
      step();

      // Redirect pending while imem not ready.
      do_reset();
      imem_ready = 0; jump = 1; jump_addr = 32'h100;
      for (int i = 0; i < 3; i++) begin
         step(); idle();
         chk("wait_pc", 64'(pc), 64'h0);
         chk("wait_IF_flush", 64'(IF_flush), 64'd1);
      end
      imem_ready = 1; step();
      chk("wait_pc_tgt", 64'(pc), 64'h100);
      chk("wait_redirect_cnt", 64'(redirect_cnt), 64'd1);
      step();
      chk("wait_pc_next", 64'(pc), 64'h104);

      // PC wrap.
      jump = 1; jump_addr = 32'hFFFF_FFFC; step(); idle();
      chk("wrap_pc_top", 64'(pc), 64'hFFFF_FFFC);
      step();
      chk("wrap_pc_zero", 64'(pc), 64'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         load_use   = ($urandom_range(0, 7) == 0);
         jr         = ($urandom_range(0, 7) == 0);
         bne        = ($urandom_range(0, 6) == 0);
         jump       = ($urandom_range(0, 5) == 0);
         jr_addr    = $urandom;
         bne_addr   = $urandom;
         jump_addr  = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 : $urandom;
         imem_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      idle(); imem_ready = 1;

      // Redirect counter saturation.
      do_reset();
      for (int i = 0; i < (1 << CW) + 5; i++) begin
         jump = 1; jump_addr = $urandom; step();
         idle(); step();
      end
      chk("redirect_cnt_sat", 64'(redirect_cnt), 64'(CMAX));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
